// File: rtl/fake_netlist_stim_seq_if.sv
// Vector stream from the stimulus sequencer to the netlist capture wrapper.
// Bit i of vec_out drives netlist input n_i; valid/ready handshake.
interface fake_netlist_stim_seq_if;
  logic [13:0] vec_out;
  logic        vec_valid;
  logic        vec_ready;

  modport master (output vec_out, output vec_valid, input vec_ready);
  modport slave  (input vec_out, input vec_valid, output vec_ready);
endinterface

// File: rtl/fake_netlist_stim_seq.sv
// LFSR stimulus sequencer for 14-input fake netlists; optional abort via STIM_SEQ_ABORT_EN.
// Latency: start at edge k gives first vector in cycle k+1; one vector per cycle when ready.
// Backpressure: vec_out/lfsr/count hold while vec_valid && !vec_ready.
module fake_netlist_stim_seq #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [13:0]            seed,
  input  logic [CNT_W-1:0]       num_vec,
`ifdef STIM_SEQ_ABORT_EN
  input  logic                   abort,
`endif
  fake_netlist_stim_seq_if.master vec_if,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [13:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             xfer;
  logic             fb;

  // Taps 14,5,3,1 form a primitive polynomial: period 16383, zero never reached.
  assign fb   = lfsr_q[13] ^ lfsr_q[4] ^ lfsr_q[2] ^ lfsr_q[0];
  assign xfer = (state_q == RUN) && vec_if.vec_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          lfsr_d      = (seed == 14'h0000) ? 14'h0001 : seed;
          remaining_d = num_vec;
          state_d     = (num_vec != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (xfer) begin
          // Last vector leaves the LFSR untouched so the count never wraps below 1.
          if (remaining_q == CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            lfsr_d      = {lfsr_q[12:0], fb};
            remaining_d = remaining_q - CNT_W'(1);
          end
        end
`ifdef STIM_SEQ_ABORT_EN
        if (abort) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs come straight from flops or a state decode.
  assign vec_if.vec_out   = lfsr_q;
  assign vec_if.vec_valid = (state_q == RUN);
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);

endmodule

// File: tb/tb_fake_netlist_stim_seq.sv
// Directed bench for fake_netlist_stim_seq; abort steps built when STIM_SEQ_ABORT_EN is defined.
module tb_fake_netlist_stim_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] seed;
  logic [15:0] num_vec;
  logic        abort;
  logic        busy;
  logic        done;

  int n_chk;
  int n_fail;

  fake_netlist_stim_seq_if vif ();

  fake_netlist_stim_seq #(.CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .seed    (seed),
    .num_vec (num_vec),
`ifdef STIM_SEQ_ABORT_EN
    .abort   (abort),
`endif
    .vec_if  (vif.master),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic kick(input logic [13:0] s, input logic [15:0] n);
    seed    = s;
    num_vec = n;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  function automatic logic [13:0] lfsr_next(input logic [13:0] v);
    return {v[12:0], v[13] ^ v[4] ^ v[2] ^ v[0]};
  endfunction

  bit seen [0:16383];

  initial begin
    int xfers;
    int idx;
    int zeros;
    int dups;
    int model_err;
    int seen_valid;
    int seen_done;
    logic [13:0] expv;
    logic [13:0] last;

    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    seed = '0;
    num_vec = '0;
    abort = 1'b0;
    vif.vec_ready = 1'b1;

    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    chk("reset vec_out",   {18'd0, vif.vec_out}, 32'h0);
    chk("reset vec_valid", {31'd0, vif.vec_valid}, 32'h0);
    chk("reset busy",      {31'd0, busy}, 32'h0);
    chk("reset done",      {31'd0, done}, 32'h0);

    // Basic run: seed 1, three vectors, ready held high.
    kick(14'h0001, 16'd3);
    chk("basic c1 vec",   {18'd0, vif.vec_out}, 32'h0001);
    chk("basic c1 valid", {31'd0, vif.vec_valid}, 32'h1);
    chk("basic c1 busy",  {31'd0, busy}, 32'h1);
    step();
    chk("basic c2 vec",   {18'd0, vif.vec_out}, 32'h0003);
    step();
    chk("basic c3 vec",   {18'd0, vif.vec_out}, 32'h0007);
    chk("basic c3 valid", {31'd0, vif.vec_valid}, 32'h1);
    step();
    chk("basic c4 done",  {31'd0, done}, 32'h1);
    chk("basic c4 valid", {31'd0, vif.vec_valid}, 32'h0);
    chk("basic c4 busy",  {31'd0, busy}, 32'h1);
    start = 1'b1;
    seed = 14'h0100;
    num_vec = 16'd5;
    step();
    start = 1'b0;
    chk("start in DONE ignored busy", {31'd0, busy}, 32'h0);
    chk("basic c5 done",  {31'd0, done}, 32'h0);
    step();
    chk("start in DONE ignored valid", {31'd0, vif.vec_valid}, 32'h0);

    // Backpressure: five stalled cycles, then two transfers.
    vif.vec_ready = 1'b0;
    kick(14'h1234, 16'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp stall vec",   {18'd0, vif.vec_out}, 32'h1234);
      chk("bp stall valid", {31'd0, vif.vec_valid}, 32'h1);
      step();
    end
    vif.vec_ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (vif.vec_valid) begin
        xfers++;
        if (xfers == 1) chk("bp vec1", {18'd0, vif.vec_out}, 32'h1234);
        if (xfers == 2) chk("bp vec2", {18'd0, vif.vec_out}, 32'h2468);
      end
      step();
    end
    chk("bp done seen",  {31'd0, done}, 32'h1);
    chk("bp transfers",  xfers, 32'd2);
    step();

    // Zero seed maps to 1; zero count emits nothing.
    kick(14'h0000, 16'd1);
    chk("seed0 vec",   {18'd0, vif.vec_out}, 32'h0001);
    chk("seed0 valid", {31'd0, vif.vec_valid}, 32'h1);
    step();
    chk("seed0 done",  {31'd0, done}, 32'h1);
    step();
    kick(14'h0155, 16'd0);
    chk("n0 c1 done",  {31'd0, done}, 32'h1);
    chk("n0 c1 valid", {31'd0, vif.vec_valid}, 32'h0);
    step();
    chk("n0 c2 busy",  {31'd0, busy}, 32'h0);
    chk("n0 c2 valid", {31'd0, vif.vec_valid}, 32'h0);
    step();

    // Full period: 16384 vectors wrap back to the seed.
    foreach (seen[i]) seen[i] = 1'b0;
    idx = 0; zeros = 0; dups = 0; model_err = 0;
    expv = 14'h2A5F;
    last = '0;
    kick(14'h2A5F, 16'd16384);
    for (int i = 0; i < 16500 && !done; i++) begin
      if (vif.vec_valid) begin
        idx++;
        last = vif.vec_out;
        if (vif.vec_out == 14'h0000) zeros++;
        if (vif.vec_out !== expv) model_err++;
        if (idx <= 16383) begin
          if (seen[vif.vec_out]) dups++;
          seen[vif.vec_out] = 1'b1;
        end
        expv = lfsr_next(expv);
      end
      step();
    end
    chk("long done seen",  {31'd0, done}, 32'h1);
    chk("long count",      idx, 32'd16384);
    chk("long last vec",   {18'd0, last}, 32'h2A5F);
    chk("long zeros",      zeros, 32'd0);
    chk("long dups",       dups, 32'd0);
    chk("long model errs", model_err, 32'd0);
    step();

    // Reset mid-run clears outputs at once and suppresses done.
    kick(14'h0ABC, 16'd10);
    step();
    rst = 1'b1;
    #1;
    chk("midrst vec",   {18'd0, vif.vec_out}, 32'h0);
    chk("midrst valid", {31'd0, vif.vec_valid}, 32'h0);
    chk("midrst busy",  {31'd0, busy}, 32'h0);
    chk("midrst done",  {31'd0, done}, 32'h0);
    step();
    step();
    rst = 1'b0;
    seen_done = 0; seen_valid = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) seen_done++;
      if (vif.vec_valid) seen_valid++;
      step();
    end
    chk("midrst no done",  seen_done, 32'd0);
    chk("midrst no valid", seen_valid, 32'd0);

    // Start pulse during RUN must not disturb the sequence.
    kick(14'h0001, 16'd3);
    chk("rs c1 vec", {18'd0, vif.vec_out}, 32'h0001);
    seed = 14'h0100;
    num_vec = 16'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rs c2 vec", {18'd0, vif.vec_out}, 32'h0003);
    step();
    chk("rs c3 vec", {18'd0, vif.vec_out}, 32'h0007);
    step();
    chk("rs c4 done", {31'd0, done}, 32'h1);
    step();
    chk("rs c5 busy", {31'd0, busy}, 32'h0);

`ifdef STIM_SEQ_ABORT_EN
    // Abort in cycle 4 coincides with the fourth accepted transfer.
    xfers = 0;
    kick(14'h0001, 16'd10);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) abort = 1'b1;
      if (vif.vec_valid && vif.vec_ready) xfers++;
      step();
    end
    abort = 1'b0;
    chk("abort transfers", xfers, 32'd4);
    chk("abort c5 done",   {31'd0, done}, 32'h1);
    chk("abort c5 valid",  {31'd0, vif.vec_valid}, 32'h0);
    step();
    chk("abort c6 busy",   {31'd0, busy}, 32'h0);
    chk("abort c6 done",   {31'd0, done}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
